hazard_ctrl_unit: RTL and testbench

Pipeline hazard controller for the five-stage 64-bit RISC-V core; it produces the per-stage write enables and the `sel` bubble control consumed by the ID/EX pipeline register. It detects load-use hazards between the instruction in ID and a load in EX, and holds the front end for a configurable number of cycles. On a taken branch resolved in MEM, it flushes the younger stages. Two saturating event counters expose stall and flush statistics for debug.

---
 rtl/hazard_ctrl_unit_if.sv | 31 +++
 rtl/hazard_ctrl_unit.sv | 99 +++++++++
 tb/tb_hazard_ctrl_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-controller bundle: ID/EX register fields and branch resolution in, stage enables and flushes out.
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_Rs1;
    logic [4:0]       IF_ID_Rs2;
    logic             IF_ID_UseRs2;
    logic [4:0]       ID_EX_Rd;
    logic             ID_EX_MemRead;
    logic             Branch_taken;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_sel;
    logic             EX_MEM_Flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output IF_ID_Rs1, IF_ID_Rs2, IF_ID_UseRs2, ID_EX_Rd, ID_EX_MemRead, Branch_taken,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_sel, EX_MEM_Flush,
        input  stall_cycles, flush_events
    );

    modport slave (
        input  IF_ID_Rs1, IF_ID_Rs2, IF_ID_UseRs2, ID_EX_Rd, ID_EX_MemRead, Branch_taken,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_sel, EX_MEM_Flush,
        output stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall and taken-branch flush control for the 5-stage pipeline.
// Latency: control outputs are combinational (Mealy) from state and inputs, same cycle.
// Backpressure: holds PC and IF/ID and bubbles ID/EX for LOAD_STALL_CYCLES per load-use hazard.
module hazard_ctrl_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_ctrl_unit_if.slave  bus
);
    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    localparam logic [2:0]       RELOAD  = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    state_e cur_state;
    logic   hz;
    logic   stall_act;
    logic   pc_we, ifid_we, ifid_flush, idex_sel, exmem_flush;

    // While reset is held the controller behaves as RUN, so a stall in progress is dropped at once.
    assign cur_state = reset ? RUN : state_q;

    assign hz = bus.ID_EX_MemRead && (bus.ID_EX_Rd != 5'd0) &&
                ((bus.ID_EX_Rd == bus.IF_ID_Rs1) ||
                 (bus.IF_ID_UseRs2 && (bus.ID_EX_Rd == bus.IF_ID_Rs2)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_act   = 1'b0;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_sel    = 1'b1;
        exmem_flush = 1'b0;

        if (bus.Branch_taken) begin
            ifid_flush  = 1'b1;
            idex_sel    = 1'b0;
            exmem_flush = 1'b1;
            state_d     = RUN;
            cnt_d       = 3'd0;
        end else if (cur_state == STALL) begin
            stall_act = 1'b1;
            cnt_d     = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                state_d = RUN;
            end
        end else if (hz) begin
            stall_act = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_d = STALL;
                cnt_d   = RELOAD;
            end
        end

        if (stall_act) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_sel = 1'b0;
        end
    end

    assign stall_cnt_d = (stall_act && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
    assign flush_cnt_d = (bus.Branch_taken && (flush_cnt_q != CNT_MAX)) ? flush_cnt_q + CNT_ONE : flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.PC_Write     = pc_we;
    assign bus.IF_ID_Write  = ifid_we;
    assign bus.IF_ID_Flush  = ifid_flush;
    assign bus.ID_EX_sel    = idex_sel;
    assign bus.EX_MEM_Flush = exmem_flush;
    assign bus.stall_cycles = stall_cnt_q;
    assign bus.flush_events = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Four controllers (stall lengths 1,3,4,2; the last with 4-bit counters) share one stimulus stream
// and are checked every cycle against a remaining-stall-count model plus literal expectations.
module tb_hazard_ctrl_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       use2 = 1'b0, mr = 1'b0, br = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.CNT_W(16)) if0 ();
    hazard_ctrl_unit_if #(.CNT_W(16)) if1 ();
    hazard_ctrl_unit_if #(.CNT_W(16)) if2 ();
    hazard_ctrl_unit_if #(.CNT_W(4))  if3 ();

    assign if0.IF_ID_Rs1 = rs1;  assign if0.IF_ID_Rs2 = rs2;  assign if0.IF_ID_UseRs2 = use2;
    assign if0.ID_EX_Rd = rd;    assign if0.ID_EX_MemRead = mr; assign if0.Branch_taken = br;
    assign if1.IF_ID_Rs1 = rs1;  assign if1.IF_ID_Rs2 = rs2;  assign if1.IF_ID_UseRs2 = use2;
    assign if1.ID_EX_Rd = rd;    assign if1.ID_EX_MemRead = mr; assign if1.Branch_taken = br;
    assign if2.IF_ID_Rs1 = rs1;  assign if2.IF_ID_Rs2 = rs2;  assign if2.IF_ID_UseRs2 = use2;
    assign if2.ID_EX_Rd = rd;    assign if2.ID_EX_MemRead = mr; assign if2.Branch_taken = br;
    assign if3.IF_ID_Rs1 = rs1;  assign if3.IF_ID_Rs2 = rs2;  assign if3.IF_ID_UseRs2 = use2;
    assign if3.ID_EX_Rd = rd;    assign if3.ID_EX_MemRead = mr; assign if3.Branch_taken = br;

    hazard_ctrl_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    hazard_ctrl_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    hazard_ctrl_unit #(.LOAD_STALL_CYCLES(4), .CNT_W(16)) dut2 (.clk(clk), .reset(reset), .bus(if2));
    hazard_ctrl_unit #(.LOAD_STALL_CYCLES(2), .CNT_W(4))  dut3 (.clk(clk), .reset(reset), .bus(if3));

    // Control bits packed as {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_sel, EX_MEM_Flush}.
    logic [4:0]  o_ctl [4];
    logic [15:0] o_sc  [4];
    logic [15:0] o_fe  [4];

    assign o_ctl[0] = {if0.PC_Write, if0.IF_ID_Write, if0.IF_ID_Flush, if0.ID_EX_sel, if0.EX_MEM_Flush};
    assign o_ctl[1] = {if1.PC_Write, if1.IF_ID_Write, if1.IF_ID_Flush, if1.ID_EX_sel, if1.EX_MEM_Flush};
    assign o_ctl[2] = {if2.PC_Write, if2.IF_ID_Write, if2.IF_ID_Flush, if2.ID_EX_sel, if2.EX_MEM_Flush};
    assign o_ctl[3] = {if3.PC_Write, if3.IF_ID_Write, if3.IF_ID_Flush, if3.ID_EX_sel, if3.EX_MEM_Flush};
    assign o_sc[0] = if0.stall_cycles;  assign o_fe[0] = if0.flush_events;
    assign o_sc[1] = if1.stall_cycles;  assign o_fe[1] = if1.flush_events;
    assign o_sc[2] = if2.stall_cycles;  assign o_fe[2] = if2.flush_events;
    assign o_sc[3] = {12'd0, if3.stall_cycles};
    assign o_fe[3] = {12'd0, if3.flush_events};

    int lsc  [4] = '{1, 3, 4, 2};
    int cmax [4] = '{65535, 65535, 65535, 15};
    int rem  [4] = '{0, 0, 0, 0};
    int m_sc [4] = '{0, 0, 0, 0};
    int m_fe [4] = '{0, 0, 0, 0};

    logic       m_hz;
    logic       m_stalling;
    logic [4:0] m_ctl;

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t got=%0d expected=%0d", name, k, $time, got, exp);
        end
    endtask

    // Model: rem = stall cycles still owed after the current one.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                m_hz = mr && (rd != 5'd0) && ((rd == rs1) || (use2 && (rd == rs2)));
                m_stalling = !reset && (rem[k] > 0);
                if (br)                     m_ctl = 5'b11101;
                else if (m_stalling || m_hz) m_ctl = 5'b00000;
                else                        m_ctl = 5'b11010;
                chk("PC_Write",     k, o_ctl[k][4], m_ctl[4]);
                chk("IF_ID_Write",  k, o_ctl[k][3], m_ctl[3]);
                chk("IF_ID_Flush",  k, o_ctl[k][2], m_ctl[2]);
                chk("ID_EX_sel",    k, o_ctl[k][1], m_ctl[1]);
                chk("EX_MEM_Flush", k, o_ctl[k][0], m_ctl[0]);
                chk("stall_cycles", k, o_sc[k], m_sc[k]);
                chk("flush_events", k, o_fe[k], m_fe[k]);
                if (reset) begin
                    rem[k] = 0; m_sc[k] = 0; m_fe[k] = 0;
                end else if (br) begin
                    rem[k] = 0;
                    if (m_fe[k] < cmax[k]) m_fe[k]++;
                end else if (m_stalling || m_hz) begin
                    rem[k] = m_stalling ? rem[k] - 1 : lsc[k] - 1;
                    if (m_sc[k] < cmax[k]) m_sc[k]++;
                end
            end
        end
    end

    task automatic vec(input logic r, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                       input logic u, input logic m, input logic b);
        @(posedge clk);
        #1;
        reset = r; rs1 = a1; rs2 = a2; rd = d; use2 = u; mr = m; br = b;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) vec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rst1();
        vec(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst1(); rst1();
        idle(1);
        chk("reset_pc", 0, o_ctl[0][4], 1'b1);
        chk("reset_sc", 0, o_sc[0], 0);
        chk("reset_fe", 3, o_fe[3], 0);

        // Load-use hazard on rs1 for one cycle.
        vec(1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
        chk("lu_hold_pc", 0, o_ctl[0][4], 1'b0);
        chk("lu_hold_sel", 0, o_ctl[0][1], 1'b0);
        idle(1);
        chk("lu_run_pc", 0, o_ctl[0][4], 1'b1);
        chk("lu_sc1", 0, o_sc[0], 1);
        chk("lu3_c1_pc", 1, o_ctl[1][4], 1'b0);
        idle(1);
        chk("lu3_c2_pc", 1, o_ctl[1][4], 1'b0);
        idle(1);
        chk("lu3_c3_pc", 1, o_ctl[1][4], 1'b1);
        idle(2);
        chk("lu3_sc", 1, o_sc[1], 3);
        chk("lu4_sc", 2, o_sc[2], 4);
        chk("lu2_sc", 3, o_sc[3], 2);

        // x0 never hazards; rs2 match ignored when rs2 unused.
        rst1();
        vec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("x0_pc", 0, o_ctl[0][4], 1'b1);
        vec(1'b0, 5'd3, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0);
        chk("rs2mask_pc", 0, o_ctl[0][4], 1'b1);
        idle(1);
        chk("mask_sc", 0, o_sc[0], 0);

        // Taken branch during a 3-cycle stall.
        rst1();
        vec(1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
        vec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("bst_ifflush", 1, o_ctl[1][2], 1'b1);
        chk("bst_exflush", 1, o_ctl[1][0], 1'b1);
        chk("bst_sel", 1, o_ctl[1][1], 1'b0);
        chk("bst_pc", 1, o_ctl[1][4], 1'b1);
        idle(1);
        chk("bst_run_pc", 1, o_ctl[1][4], 1'b1);
        chk("bst_fe", 1, o_fe[1], 1);
        chk("bst_sc", 1, o_sc[1], 1);
        idle(2);

        // Reset during a 4-cycle stall.
        rst1();
        vec(1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
        rst1();
        idle(1);
        chk("rms_pc", 2, o_ctl[2][4], 1'b1);
        chk("rms_sc", 2, o_sc[2], 0);
        chk("rms_fe", 2, o_fe[2], 0);

        // Flush counter saturation.
        rst1();
        for (int i = 0; i < 20; i++) vec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("sat_fe4", 3, o_fe[3], 15);
        chk("sat_fe16", 0, o_fe[0], 20);

        // Mixed vectors: rs2 hazard, hazard with branch, no-load match, mismatch.
        rst1();
        vec(1'b0, 5'd1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0);
        idle(4);
        vec(1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1);
        idle(1);
        chk("hzbr_sc", 0, o_sc[0], 1);
        chk("hzbr_fe", 0, o_fe[0], 1);
        vec(1'b0, 5'd4, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0);
        vec(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        idle(4);

        // Back-to-back hazards saturate the narrow stall counter.
        rst1();
        for (int i = 0; i < 20; i++) vec(1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("sat_sc4", 3, o_sc[3], 15);
        chk("sat_sc16", 0, o_sc[0], 20);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
